// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - opcode, ALU code, MDR source and step encodings for control_sequencer
package control_sequencer_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_SHR = 4'b0111;
  localparam logic [3:0] ALU_SHL = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1110;
  localparam logic [3:0] ALU_DIV = 4'b1111;

  localparam logic [1:0] MDR_BUS = 2'b00;
  localparam logic [1:0] MDR_MEM = 2'b01;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_t;

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      default:         return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_alu_imm(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - sequencer-to-datapath strobe and status bundle
interface control_sequencer_if;

  logic [31:0] IR;
  logic        Branch;
  logic        stop;
  logic        run;

  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout;
  logic PCin, IRin, Yin, MARin, MDRin, HIin, LOin, OutPortin, Zin, Zlowin, Zhighin;
  logic Rin, Rout, BAout, GRA, GRB, GRC;
  logic read, write, IncPc;
  logic [1:0] mdr_read;
  logic [3:0] control;

  modport master (
    input  IR, Branch, stop,
    output run,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
    output PCin, IRin, Yin, MARin, MDRin, HIin, LOin, OutPortin, Zin, Zlowin, Zhighin,
    output Rin, Rout, BAout, GRA, GRB, GRC,
    output read, write, IncPc, mdr_read, control
  );

  modport slave (
    output IR, Branch, stop,
    input  run,
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
    input  PCin, IRin, Yin, MARin, MDRin, HIin, LOin, OutPortin, Zin, Zlowin, Zhighin,
    input  Rin, Rout, BAout, GRA, GRB, GRC,
    input  read, write, IncPc, mdr_read, control
  );

endinterface

// File: rtl/control_sequencer_step_counter.sv
// rtl/control_sequencer_step_counter.sv - T0..T7 step counter with synchronous clear and halt hold
module control_sequencer_step_counter
  import control_sequencer_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  hold,
  output step_t step
);

  // hold outranks clear so a halt raised on an instruction's last step freezes in place
  always_ff @(posedge clk) begin
    if (!reset) begin
      step <= T0;
    end else if (hold) begin
      step <= step;
    end else if (clear) begin
      step <= T0;
    end else begin
      step <= step_t'(step + 3'd1);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute strobe decoder for the shared-bus datapath
// MULDIV_EN enables the mul/div sequences; otherwise those opcodes decode as nop.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.master bus
);

  step_t      step;
  logic       halted;
  logic       branch_taken;
  logic       last;
  logic       halt_req;
  logic       latch_branch;
  logic       hold;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];
  assign hold      = halted | halt_req;

  control_sequencer_step_counter step_counter (
    .clk   (clk),
    .reset (reset),
    .clear (last),
    .hold  (hold),
    .step  (step)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      halted       <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      if (halt_req) halted <= 1'b1;
      if (latch_branch) branch_taken <= bus.Branch;
    end
  end

  // Everything stays at zero unless out of reset and not halted, which also makes an
  // aborted instruction drop its strobes in the very cycle reset goes low.
  always_comb begin
    bus.run       = 1'b0;
    bus.PCout     = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.MDRout    = 1'b0;
    bus.HIout     = 1'b0;
    bus.LOout     = 1'b0;
    bus.InPortout = 1'b0;
    bus.Cout      = 1'b0;
    bus.PCin      = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0;
    bus.OutPortin = 1'b0;
    bus.Zlowin    = 1'b0;
    bus.Rin       = 1'b0;
    bus.Rout      = 1'b0;
    bus.BAout     = 1'b0;
    bus.GRA       = 1'b0;
    bus.GRB       = 1'b0;
    bus.GRC       = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.IncPc     = 1'b0;
    bus.mdr_read  = MDR_BUS;
    bus.control   = 4'b0000;
`ifdef MULDIV_EN
    bus.Zhighout  = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
    bus.Zhighin   = 1'b0;
`endif
    last          = 1'b0;
    halt_req      = 1'b0;
    latch_branch  = 1'b0;

    if (reset && !halted) begin
      bus.run = 1'b1;
      case (step)
        T0: begin
          if (bus.stop) begin
            bus.run  = 1'b0;
            halt_req = 1'b1;
          end else begin
            bus.PCout  = 1'b1;
            bus.MARin  = 1'b1;
            bus.IncPc  = 1'b1;
            bus.Zlowin = 1'b1;
          end
        end
        T1: begin
          bus.Zlowout  = 1'b1;
          bus.PCin     = 1'b1;
          bus.read     = 1'b1;
          bus.mdr_read = MDR_MEM;
          bus.MDRin    = 1'b1;
        end
        T2: begin
          bus.MDRout = 1'b1;
          bus.IRin   = 1'b1;
        end
        default: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: begin
              case (step)
                T3: begin
                  bus.GRB  = 1'b1;
                  bus.Rout = 1'b1;
                  bus.Yin  = 1'b1;
                end
                T4: begin
                  if (is_alu_imm(op)) begin
                    bus.Cout = 1'b1;
                  end else begin
                    bus.GRC  = 1'b1;
                    bus.Rout = 1'b1;
                  end
                  bus.control = alu_code(op);
                  bus.Zlowin  = 1'b1;
                end
                T5: begin
                  bus.Zlowout = 1'b1;
                  bus.GRA     = 1'b1;
                  bus.Rin     = 1'b1;
                  last        = 1'b1;
                end
                default: last = 1'b1;
              endcase
            end
            OP_LD, OP_LDI, OP_ST: begin
              case (step)
                T3: begin
                  bus.GRB   = 1'b1;
                  bus.BAout = 1'b1;
                  bus.Yin   = 1'b1;
                end
                T4: begin
                  bus.Cout    = 1'b1;
                  bus.control = ALU_ADD;
                  bus.Zlowin  = 1'b1;
                end
                T5: begin
                  bus.Zlowout = 1'b1;
                  if (op == OP_LDI) begin
                    bus.GRA = 1'b1;
                    bus.Rin = 1'b1;
                    last    = 1'b1;
                  end else begin
                    bus.MARin = 1'b1;
                  end
                end
                T6: begin
                  bus.MDRin = 1'b1;
                  if (op == OP_ST) begin
                    bus.GRA  = 1'b1;
                    bus.Rout = 1'b1;
                  end else begin
                    bus.read     = 1'b1;
                    bus.mdr_read = MDR_MEM;
                  end
                end
                T7: begin
                  if (op == OP_ST) begin
                    bus.write = 1'b1;
                  end else begin
                    bus.MDRout = 1'b1;
                    bus.GRA    = 1'b1;
                    bus.Rin    = 1'b1;
                  end
                  last = 1'b1;
                end
                default: last = 1'b1;
              endcase
            end
            OP_BR: begin
              case (step)
                T3: begin
                  bus.GRA      = 1'b1;
                  bus.Rout     = 1'b1;
                  latch_branch = 1'b1;
                end
                T4: begin
                  bus.PCout = 1'b1;
                  bus.Yin   = 1'b1;
                end
                T5: begin
                  bus.Cout    = 1'b1;
                  bus.control = ALU_ADD;
                  bus.Zlowin  = 1'b1;
                end
                T6: begin
                  bus.Zlowout = 1'b1;
                  bus.PCin    = branch_taken;
                  last        = 1'b1;
                end
                default: last = 1'b1;
              endcase
            end
`ifdef MULDIV_EN
            OP_MUL, OP_DIV: begin
              case (step)
                T3: begin
                  bus.GRA  = 1'b1;
                  bus.Rout = 1'b1;
                  bus.Yin  = 1'b1;
                end
                T4: begin
                  bus.GRB     = 1'b1;
                  bus.Rout    = 1'b1;
                  bus.control = alu_code(op);
                  bus.Zlowin  = 1'b1;
                  bus.Zhighin = 1'b1;
                end
                T5: begin
                  bus.Zlowout = 1'b1;
                  bus.LOin    = 1'b1;
                end
                T6: begin
                  bus.Zhighout = 1'b1;
                  bus.HIin     = 1'b1;
                  last         = 1'b1;
                end
                default: last = 1'b1;
              endcase
            end
`endif
            // One-step instructions only ever reach T3, so no inner step decode is needed
            OP_JR: begin
              bus.GRA  = 1'b1;
              bus.Rout = 1'b1;
              bus.PCin = 1'b1;
              last     = 1'b1;
            end
            OP_MFHI: begin
              bus.HIout = 1'b1;
              bus.GRA   = 1'b1;
              bus.Rin   = 1'b1;
              last      = 1'b1;
            end
            OP_MFLO: begin
              bus.LOout = 1'b1;
              bus.GRA   = 1'b1;
              bus.Rin   = 1'b1;
              last      = 1'b1;
            end
            OP_IN: begin
              bus.InPortout = 1'b1;
              bus.GRA       = 1'b1;
              bus.Rin       = 1'b1;
              last          = 1'b1;
            end
            OP_OUT: begin
              bus.GRA       = 1'b1;
              bus.Rout      = 1'b1;
              bus.OutPortin = 1'b1;
              last          = 1'b1;
            end
            OP_HALT: halt_req = 1'b1;
            OP_NOP:  last = 1'b1;
            default: last = 1'b1;
          endcase
        end
      endcase
    end
  end

  assign bus.Zin = bus.Zlowin;

`ifndef MULDIV_EN
  assign bus.Zhighout = 1'b0;
  assign bus.HIin     = 1'b0;
  assign bus.LOin     = 1'b0;
  assign bus.Zhighin  = 1'b0;
`endif

endmodule
